// File: rtl/uart_mem_loader.sv
// Framed UART-to-RAM loader: 'w' ADDR_HI ADDR_LO LEN DATA.. [CKSUM] -> one status byte.
// Build option LOADER_CKSUM_EN: include a trailing checksum byte and answer 'K'/'E'.
module uart_mem_loader #(
  parameter int TIMEOUT_CYCLES = 12000000,
  parameter int ADDR_W         = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  input  logic              tx_busy,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              active
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CKSUM, S_RESP_WAIT, S_RESP_END
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        count;
  logic [TW-1:0]     timer;
`ifdef LOADER_CKSUM_EN
  logic [7:0]        cksum;
`endif

  logic take, in_frame, timeout_hit;

  // rx_rd is still high the cycle after a consume, so a held byte is never taken twice
  assign take        = rx_valid && !rx_rd;
  assign in_frame    = (state != S_IDLE) && (state != S_RESP_WAIT) && (state != S_RESP_END);
  assign timeout_hit = in_frame && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rx_rd     <= 1'b0;
      tx_wr     <= 1'b0;
      tx_data   <= 8'h00;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= 8'h00;
      active    <= 1'b0;
      ptr       <= '0;
      count     <= '0;
      timer     <= '0;
`ifdef LOADER_CKSUM_EN
      cksum     <= 8'h00;
`endif
    end else begin
      rx_rd  <= 1'b0;
      tx_wr  <= 1'b0;
      mem_we <= 1'b0;
      if (timeout_hit) begin
        // abandon the frame silently; a byte arriving now is left for S_IDLE
        state  <= S_IDLE;
        active <= 1'b0;
        timer  <= '0;
      end else begin
        if (in_frame) timer <= take ? '0 : timer + TW'(1);
        case (state)
          S_IDLE: if (take) begin
            rx_rd <= 1'b1;
            if (rx_data == 8'h77) begin
              state  <= S_ADDR_HI;
              active <= 1'b1;
              timer  <= '0;
            end
          end
          S_ADDR_HI: if (take) begin
            rx_rd            <= 1'b1;
            ptr[ADDR_W-1:8]  <= rx_data[ADDR_W-9:0];
            state            <= S_ADDR_LO;
          end
          S_ADDR_LO: if (take) begin
            rx_rd    <= 1'b1;
            ptr[7:0] <= rx_data;
            state    <= S_LEN;
          end
          S_LEN: if (take) begin
            rx_rd <= 1'b1;
            count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
`ifdef LOADER_CKSUM_EN
            cksum <= 8'h00;
`endif
            state <= S_DATA;
          end
          S_DATA: if (take) begin
            rx_rd     <= 1'b1;
            mem_we    <= 1'b1;
            mem_waddr <= ptr;
            mem_wdata <= rx_data;
            ptr       <= ptr + ADDR_W'(1);
            count     <= count - 9'd1;
`ifdef LOADER_CKSUM_EN
            cksum     <= cksum + rx_data;
            if (count == 9'd1) state <= S_CKSUM;
`else
            if (count == 9'd1) begin
              tx_data <= 8'h4B;
              state   <= S_RESP_WAIT;
            end
`endif
          end
`ifdef LOADER_CKSUM_EN
          S_CKSUM: if (take) begin
            rx_rd   <= 1'b1;
            tx_data <= (rx_data == cksum) ? 8'h4B : 8'h45;
            state   <= S_RESP_WAIT;
          end
`endif
          S_RESP_WAIT: if (!tx_busy) begin
            tx_wr <= 1'b1;
            state <= S_RESP_END;
          end
          S_RESP_END: begin
            state  <= S_IDLE;
            active <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader; follows LOADER_CKSUM_EN the same way the RTL does.
module tb_uart_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       tx_busy;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       mem_we;
  logic [8:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       active;

  int compared   = 0;
  int mismatched = 0;

`ifdef LOADER_CKSUM_EN
  localparam logic [7:0] MIS_RESP = 8'h45;
`else
  localparam logic [7:0] MIS_RESP = 8'h4B;
`endif

  always #5 clk = ~clk;

  uart_mem_loader #(.TIMEOUT_CYCLES(100), .ADDR_W(9)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .active(active)
  );

  // monitor: log every write, response and consume
  logic [8:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] tx_q[$];
  int         rd_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) begin wa_q.push_back(mem_waddr); wd_q.push_back(mem_wdata); end
    if (tx_wr) tx_q.push_back(tx_data);
    if (rx_rd) rd_cnt <= rd_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!rx_rd && n < 20);
    if (!rx_rd) begin
      compared++; mismatched++;
      $display("FAIL rx_consume: byte %h not consumed after %0d cycles", b, n);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (active && n < 400) begin @(negedge clk); n++; end
    ok = !active;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (active !== 1'b0) begin mismatched++; $display("FAIL reset_active: got %b want 0", active); end
    compared++; if ({rx_rd, tx_wr, mem_we} !== 3'b000) begin mismatched++; $display("FAIL reset_strobes: got %b want 000", {rx_rd, tx_wr, mem_we}); end
    compared++; if (tx_data !== 8'h00) begin mismatched++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    compared++; if ({mem_waddr, mem_wdata} !== 17'h0) begin mismatched++; $display("FAIL reset_mem: got %h/%h want 0/0", mem_waddr, mem_wdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int wb = wa_q.size(), tb0 = tx_q.size();
    bit ok;
    logic [8:0] ea[3] = '{9'h010, 9'h011, 9'h012};
    logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
    send_byte(8'h77);
    compared++; if (active !== 1'b1) begin mismatched++; $display("FAIL basic_active: got %b want 1", active); end
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h66);
`endif
    wait_idle(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL basic_idle: active still %b", active); end
    compared++; if (wa_q.size() - wb !== 3) begin mismatched++; $display("FAIL basic_nwrites: got %0d want 3", wa_q.size() - wb); end
    for (int i = 0; i < 3; i++) if (wa_q.size() > wb + i) begin
      compared++;
      if ({wa_q[wb+i], wd_q[wb+i]} !== {ea[i], ed[i]}) begin
        mismatched++; $display("FAIL basic_write%0d: got %h=%h want %h=%h", i, wa_q[wb+i], wd_q[wb+i], ea[i], ed[i]);
      end
    end
    compared++; if (tx_q.size() - tb0 !== 1) begin mismatched++; $display("FAIL basic_ntx: got %0d want 1", tx_q.size() - tb0); end
    else begin
      compared++; if (tx_q[tb0] !== 8'h4B) begin mismatched++; $display("FAIL basic_resp: got %h want 4B", tx_q[tb0]); end
    end
  endtask

  task automatic test_wrap;
    int wb = wa_q.size(), tb0 = tx_q.size();
    bit ok;
    send_byte(8'h77); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h65);
`endif
    wait_idle(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL wrap_idle: active still %b", active); end
    compared++; if (wa_q.size() - wb !== 2) begin mismatched++; $display("FAIL wrap_nwrites: got %0d want 2", wa_q.size() - wb); end
    else begin
      compared++; if ({wa_q[wb], wd_q[wb]} !== {9'h1FF, 8'hAA}) begin mismatched++; $display("FAIL wrap_w0: got %h=%h want 1FF=AA", wa_q[wb], wd_q[wb]); end
      compared++; if ({wa_q[wb+1], wd_q[wb+1]} !== {9'h000, 8'hBB}) begin mismatched++; $display("FAIL wrap_w1: got %h=%h want 000=BB", wa_q[wb+1], wd_q[wb+1]); end
    end
    compared++; if (tx_q.size() - tb0 !== 1) begin mismatched++; $display("FAIL wrap_ntx: got %0d want 1", tx_q.size() - tb0); end
    else begin
      compared++; if (tx_q[tb0] !== 8'h4B) begin mismatched++; $display("FAIL wrap_resp: got %h want 4B", tx_q[tb0]); end
    end
  endtask

  task automatic test_mismatch;
    int wb = wa_q.size(), tb0 = tx_q.size();
    bit ok;
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01); send_byte(8'h5A);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h00);
`endif
    wait_idle(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL mis_idle: active still %b", active); end
    compared++; if (wa_q.size() - wb !== 1) begin mismatched++; $display("FAIL mis_nwrites: got %0d want 1", wa_q.size() - wb); end
    else begin
      compared++; if ({wa_q[wb], wd_q[wb]} !== {9'h020, 8'h5A}) begin mismatched++; $display("FAIL mis_write: got %h=%h want 020=5A", wa_q[wb], wd_q[wb]); end
    end
    compared++; if (tx_q.size() - tb0 !== 1) begin mismatched++; $display("FAIL mis_ntx: got %0d want 1", tx_q.size() - tb0); end
    else begin
      compared++; if (tx_q[tb0] !== MIS_RESP) begin mismatched++; $display("FAIL mis_resp: got %h want %h", tx_q[tb0], MIS_RESP); end
    end
  endtask

  task automatic test_garbage;
    int wb = wa_q.size(), tb0 = tx_q.size(), rb = rd_cnt;
    bit ok;
    send_byte(8'h41); send_byte(8'h62);
    repeat (5) @(negedge clk);
    compared++; if (rd_cnt - rb !== 2) begin mismatched++; $display("FAIL garb_consumed: got %0d want 2", rd_cnt - rb); end
    compared++; if (active !== 1'b0) begin mismatched++; $display("FAIL garb_active: got %b want 0", active); end
    compared++; if ((wa_q.size() - wb) + (tx_q.size() - tb0) !== 0) begin mismatched++; $display("FAIL garb_side_effects: got %0d events want 0", (wa_q.size() - wb) + (tx_q.size() - tb0)); end
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h30); send_byte(8'h01); send_byte(8'h7E);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h7E);
`endif
    wait_idle(ok);
    compared++; if (wa_q.size() - wb !== 1) begin mismatched++; $display("FAIL garb_nwrites: got %0d want 1", wa_q.size() - wb); end
    else begin
      compared++; if ({wa_q[wb], wd_q[wb]} !== {9'h030, 8'h7E}) begin mismatched++; $display("FAIL garb_write: got %h=%h want 030=7E", wa_q[wb], wd_q[wb]); end
    end
    compared++; if (tx_q.size() - tb0 !== 1) begin mismatched++; $display("FAIL garb_ntx: got %0d want 1", tx_q.size() - tb0); end
    else begin
      compared++; if (tx_q[tb0] !== 8'h4B) begin mismatched++; $display("FAIL garb_resp: got %h want 4B", tx_q[tb0]); end
    end
  endtask

  task automatic test_len256;
    int wb = wa_q.size(), tb0 = tx_q.size();
    bit ok;
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'h01);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h00);
`endif
    wait_idle(ok);
    compared++; if (wa_q.size() - wb !== 256) begin mismatched++; $display("FAIL len256_nwrites: got %0d want 256", wa_q.size() - wb); end
    else for (int i = 0; i < 256; i++) begin
      compared++;
      if ({wa_q[wb+i], wd_q[wb+i]} !== {9'(i), 8'h01}) begin
        mismatched++; $display("FAIL len256_write%0d: got %h=%h want %h=01", i, wa_q[wb+i], wd_q[wb+i], 9'(i));
      end
    end
    compared++; if (tx_q.size() - tb0 !== 1) begin mismatched++; $display("FAIL len256_ntx: got %0d want 1", tx_q.size() - tb0); end
    else begin
      compared++; if (tx_q[tb0] !== 8'h4B) begin mismatched++; $display("FAIL len256_resp: got %h want 4B", tx_q[tb0]); end
    end
  endtask

  task automatic test_timeout;
    int wb, tb0 = tx_q.size();
    bit ok;
    send_byte(8'h77); send_byte(8'h00);
    repeat (95) @(negedge clk);
    compared++; if (active !== 1'b1) begin mismatched++; $display("FAIL to_early: active got %b want 1", active); end
    repeat (10) @(negedge clk);
    compared++; if (active !== 1'b0) begin mismatched++; $display("FAIL to_expired: active got %b want 0", active); end
    compared++; if (tx_q.size() - tb0 !== 0) begin mismatched++; $display("FAIL to_no_resp: got %0d responses want 0", tx_q.size() - tb0); end
    wb = wa_q.size();
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h40); send_byte(8'h01); send_byte(8'h33);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h33);
`endif
    wait_idle(ok);
    compared++; if (wa_q.size() - wb !== 1) begin mismatched++; $display("FAIL to_nwrites: got %0d want 1", wa_q.size() - wb); end
    else begin
      compared++; if ({wa_q[wb], wd_q[wb]} !== {9'h040, 8'h33}) begin mismatched++; $display("FAIL to_write: got %h=%h want 040=33", wa_q[wb], wd_q[wb]); end
    end
    compared++; if (tx_q.size() - tb0 !== 1) begin mismatched++; $display("FAIL to_ntx: got %0d want 1", tx_q.size() - tb0); end
  endtask

  task automatic test_tx_busy;
    int tb0 = tx_q.size();
    bit ok;
    tx_busy = 1'b1;
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h50); send_byte(8'h01); send_byte(8'h44);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h44);
`endif
    repeat (50) @(negedge clk);
    compared++; if (tx_q.size() - tb0 !== 0) begin mismatched++; $display("FAIL busy_held: got %0d responses want 0", tx_q.size() - tb0); end
    compared++; if (active !== 1'b1) begin mismatched++; $display("FAIL busy_active: got %b want 1", active); end
    tx_busy = 1'b0;
    wait_idle(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL busy_idle: active still %b", active); end
    compared++; if (tx_q.size() - tb0 !== 1) begin mismatched++; $display("FAIL busy_ntx: got %0d want 1", tx_q.size() - tb0); end
    else begin
      compared++; if (tx_q[tb0] !== 8'h4B) begin mismatched++; $display("FAIL busy_resp: got %h want 4B", tx_q[tb0]); end
    end
  endtask

  task automatic test_reset_midframe;
    int tb0 = tx_q.size();
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h60);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    compared++; if (active !== 1'b0) begin mismatched++; $display("FAIL rstmid_active: got %b want 0", active); end
    compared++; if (tx_q.size() - tb0 !== 0) begin mismatched++; $display("FAIL rstmid_no_resp: got %0d want 0", tx_q.size() - tb0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_mismatch;
    test_garbage;
    test_len256;
    test_timeout;
    test_tx_busy;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
